// File: rtl/digito_renderizador.sv
// digito_renderizador
// Renders a decimal digit as an 11x11 image and streams it row-major, one
// 8-bit pixel per valid/ready handshake. Glyphs come from a 7-segment stroke
// font held in an internal ROM; digits 10..15 render blank and flag bad_digit.
//
// Ports
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   digito, start       digit to render; latched when start && !busy
//   busy                high from the cycle after acceptance through done
//   pix_valid/pix_ready pixel handshake; outputs hold while stalled
//   pix_data            FG (255) or BG (0)
//   pix_x, pix_y        column / row of the current pixel (0..10)
//   pix_last            marks pixel (10,10)
//   done                one-cycle pulse after the last handshake
//   bad_digit           digito > 9 at the last accepted start
module digito_renderizador (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digito,
  input  logic       start,
  output logic       busy,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [7:0] pix_data,
  output logic [3:0] pix_x,
  output logic [3:0] pix_y,
  output logic       pix_last,
  output logic       done,
  output logic       bad_digit
);

  localparam logic [7:0] FG = 8'd255;
  localparam logic [7:0] BG = 8'd0;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  digit_q;
  logic [10:0] row_q;
  logic        hs;

  // Font ROM: segment bits are {g,f,e,d,c,b,a}; out-of-range digits light nothing.
  function automatic logic [10:0] rom_row(input logic [3:0] d, input logic [3:0] y);
    logic [6:0]  seg;
    logic [10:0] row;
    seg = 7'b0;
    row = 11'b0;
    case (d)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1101111;
      default: seg = 7'b0;
    endcase
    case (y)
      4'd1: if (seg[0]) row[7:3] = 5'h1f;
      4'd5: if (seg[6]) row[7:3] = 5'h1f;
      4'd9: if (seg[3]) row[7:3] = 5'h1f;
      4'd2, 4'd3, 4'd4: begin
        row[2] = seg[5];
        row[8] = seg[1];
      end
      4'd6, 4'd7, 4'd8: begin
        row[2] = seg[4];
        row[8] = seg[2];
      end
      default: row = 11'b0;
    endcase
    return row;
  endfunction

  assign hs = (state_q == STREAM) && pix_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = STREAM;
      STREAM:  if (hs && pix_x == 4'd10) state_d = (pix_y == 4'd10) ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      digit_q   <= 4'd0;
      bad_digit <= 1'b0;
      row_q     <= 11'b0;
      pix_x     <= 4'd0;
      pix_y     <= 4'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          digit_q   <= digito;
          bad_digit <= (digito > 4'd9);
        end
        LOAD: row_q <= rom_row(digit_q, pix_y);
        STREAM: if (hs) begin
          if (pix_x < 4'd10) begin
            pix_x <= pix_x + 4'd1;
          end else if (pix_y < 4'd10) begin
            pix_x <= 4'd0;
            pix_y <= pix_y + 4'd1;
          end
        end
        DONE: begin
          pix_x <= 4'd0;
          pix_y <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so a stall cannot disturb them.
  assign busy      = (state_q != IDLE);
  assign pix_valid = (state_q == STREAM);
  assign done      = (state_q == DONE);
  assign pix_last  = pix_valid && (pix_x == 4'd10) && (pix_y == 4'd10);
  assign pix_data  = (pix_valid && row_q[pix_x]) ? FG : BG;

endmodule

// File: tb/tb_digito_renderizador.sv
// Self-checking bench for digito_renderizador. A geometric reference model
// (segment rectangles plus a per-digit segment list) predicts every pixel.
module tb_digito_renderizador;

  logic       clk = 1'b0;
  logic       reset, start, pix_ready;
  logic [3:0] digito;
  logic       busy, pix_valid, pix_last, done, bad_digit;
  logic [7:0] pix_data;
  logic [3:0] pix_x, pix_y;

  always #5 clk = ~clk;

  digito_renderizador dut (
    .clk(clk), .reset(reset), .digito(digito), .start(start),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_last(pix_last), .done(done), .bad_digit(bad_digit)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] frame [0:10][0:10];
  logic [7:0] ref_frame [0:10][0:10];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  string segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic bit has_seg(int d, byte s);
    if (d > 9) return 1'b0;
    for (int i = 0; i < segs[d].len(); i++)
      if (segs[d].getc(i) == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_pix(int d, int x, int y);
    bit on;
    on = (has_seg(d, "a") && y == 1 && x >= 3 && x <= 7) ||
         (has_seg(d, "g") && y == 5 && x >= 3 && x <= 7) ||
         (has_seg(d, "d") && y == 9 && x >= 3 && x <= 7) ||
         (has_seg(d, "f") && x == 2 && y >= 2 && y <= 4) ||
         (has_seg(d, "b") && x == 8 && y >= 2 && y <= 4) ||
         (has_seg(d, "e") && x == 2 && y >= 6 && y <= 8) ||
         (has_seg(d, "c") && x == 8 && y >= 6 && y <= 8);
    return on ? 255 : 0;
  endfunction

  function automatic int fg_count();
    int n = 0;
    for (int y = 0; y < 11; y++)
      for (int x = 0; x < 11; x++)
        if (frame[y][x] == 8'd255) n++;
    return n;
  endfunction

  // Start a frame, run it to completion and check it pixel by pixel.
  // bp = stall percentage on pix_ready; inj_cyc = busy cycle at which a
  // stray start with digito=7 is pulsed (-1 for none).
  task automatic run_frame(input int d, input int bp, input int inj_cyc);
    int busy_cnt, hs_cnt, last_hs, done_cyc, done_cnt;
    bit pv, pr, pl;
    logic [7:0] pd;
    logic [3:0] px, py;
    for (int y = 0; y < 11; y++)
      for (int x = 0; x < 11; x++) frame[y][x] = 8'd1;
    @(negedge clk);
    digito = d[3:0];
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    digito = 4'($urandom);
    chk("busy_rise", busy, 1);
    chk("bad_digit", bad_digit, int'(d > 9));
    busy_cnt = 0; hs_cnt = 0; last_hs = -10; done_cyc = -1; done_cnt = 0;
    pv = 0; pr = 0; pl = 0; pd = 0; px = 0; py = 0;
    for (int cyc = 0; cyc < 3000 && busy; cyc++) begin
      busy_cnt++;
      if (pv && !pr) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_data", pix_data, pd);
        chk("stall_x", pix_x, px);
        chk("stall_y", pix_y, py);
        chk("stall_last", pix_last, pl);
      end
      if (busy_cnt == inj_cyc) begin
        start  = 1'b1;
        digito = 4'd7;
      end else begin
        start  = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_valid_low", pix_valid, 0);
      end
      pix_ready = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
      if (pix_valid && pix_ready) begin
        chk("pix_x", pix_x, hs_cnt % 11);
        chk("pix_y", pix_y, hs_cnt / 11);
        chk("pix_data", pix_data, model_pix(d, hs_cnt % 11, hs_cnt / 11));
        chk("pix_last", pix_last, int'(hs_cnt == 120));
        if (pix_x <= 4'd10 && pix_y <= 4'd10) frame[pix_y][pix_x] = pix_data;
        hs_cnt++;
        last_hs = cyc;
      end
      pv = pix_valid; pr = pix_ready; pd = pix_data;
      px = pix_x; py = pix_y; pl = pix_last;
      @(negedge clk);
    end
    start = 1'b0;
    chk("frame_finished", busy, 0);
    chk("pix_count", hs_cnt, 121);
    chk("done_pulses", done_cnt, 1);
    chk("done_after_last", done_cyc, last_hs + 1);
    if (bp == 0) chk("busy_cycles", busy_cnt, 133);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int seen_done;
    bit hit;
    reset = 1'b1; start = 1'b0; digito = 4'd0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    chk("rst_last", pix_last, 0);
    chk("rst_done", done, 0);
    chk("rst_bad", bad_digit, 0);
    reset = 1'b0;

    // digit 8, free-running sink, plus hand-picked pixels
    run_frame(8, 0, -1);
    chk("d8_3_1", frame[1][3], 255);
    chk("d8_2_3", frame[3][2], 255);
    chk("d8_8_7", frame[7][8], 255);
    chk("d8_5_5", frame[5][5], 255);
    chk("d8_5_9", frame[9][5], 255);
    chk("d8_0_0", frame[0][0], 0);
    chk("d8_5_3", frame[3][5], 0);

    run_frame(1, 0, -1);
    chk("d1_fg_count", fg_count(), 6);
    for (int y = 2; y <= 8; y++)
      if (y != 5) chk("d1_col8", frame[y][8], 255);

    run_frame(12, 0, -1);
    chk("d12_fg_count", fg_count(), 0);
    chk("d12_bad_held", bad_digit, 1);
    run_frame(3, 0, -1);
    chk("d3_bad_clear", bad_digit, 0);

    // digit 0 reference, then the same digit under ~50% backpressure
    run_frame(0, 0, -1);
    for (int y = 0; y < 11; y++)
      for (int x = 0; x < 11; x++) ref_frame[y][x] = frame[y][x];
    run_frame(0, 50, -1);
    for (int y = 0; y < 11; y++)
      for (int x = 0; x < 11; x++) chk("bp_same_frame", frame[y][x], ref_frame[y][x]);

    // stray start mid-frame is ignored; the next start renders 7
    run_frame(2, 0, 40);
    run_frame(7, 0, -1);

    // reset in the middle of a frame
    @(negedge clk);
    digito = 4'd8; start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      if (pix_valid && pix_x == 4'd4 && pix_y == 4'd6) hit = 1'b1;
      else @(negedge clk);
    end
    chk("reach_4_6", hit, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", pix_valid, 0);
    chk("mid_rst_x", pix_x, 0);
    chk("mid_rst_y", pix_y, 0);
    reset = 1'b0;
    seen_done = 0;
    repeat (6) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", seen_done, 0);
    run_frame(8, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/digito_renderizador.md
# digito_renderizador

Generates the 11x11 pixel image of a decimal digit and streams it out row-major, one 8-bit pixel per handshake. It is the inverse of the digit-recognition path, which takes an 11x11 image and returns a 4-bit digit. It feeds score/overlay drawing and lets benches drive the recognizer with known-good images. Glyphs are a fixed 7-segment stroke font held in an internal ROM.

## Interface
- FG, 8'd255, pixel value for glyph stroke pixels
- BG, 8'd0, pixel value for background pixels
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- digito  in  4  digit to render; sampled only on an accepted start
- start  in  1  request; accepted when start && !busy
- busy  out  1  high from the cycle after acceptance through the done cycle
- pix_valid  out  1  pix_data/pix_x/pix_y/pix_last are valid
- pix_ready  in  1  sink accepts the pixel when pix_valid && pix_ready
- pix_data  out  8  FG or BG
- pix_x  out  4  column 0..10
- pix_y  out  4  row 0..10
- pix_last  out  1  high on pixel (10,10) only
- done  out  1  one-cycle pulse after the last pixel handshake
- bad_digit  out  1  latched at acceptance: digito > 9; held until the next accepted start

## Operation
- Reset, and the reset value of every output: busy=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_last=0, done=0, bad_digit=0; FSM=IDLE.
- FSM states: IDLE, LOAD, STREAM, DONE.
- IDLE: on start, latch digito and set bad_digit = (digito>9), then go to LOAD.
- LOAD: read the 11-bit row mask for (digit, pix_y) from the ROM into a row register; pix_valid=0; next state is STREAM.
- STREAM: pix_valid=1; pix_data = row_mask[pix_x] ? FG : BG. On a handshake:
  - if pix_x<10, increment pix_x;
  - else if pix_y<10, set pix_x=0, increment pix_y, go to LOAD;
  - else go to DONE.
- DONE: done=1 and busy=1 for one cycle; then IDLE with busy=0, and pix_x and pix_y cleared.
- Glyph segments (x = column, y = row), each 1 pixel thick:
  - a: y=1, x=3..7
  - g: y=5, x=3..7
  - d: y=9, x=3..7
  - f: x=2, y=2..4
  - b: x=8, y=2..4
  - e: x=2, y=6..8
  - c: x=8, y=6..8
- Digit-to-segment map, standard 7-segment:
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg
  - 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg
- Digits 10..15 render all-BG and assert bad_digit.
- Row 0, row 10, column 0, column 10 and the corner pixels are always BG.
- start while busy is ignored; it is neither queued nor does it alter digito.

## Timing
- start accepted at edge 0 → busy=1 and LOAD at edge 1 → first pix_valid at edge 2.
- While pix_valid && !pix_ready: pix_data, pix_x, pix_y and pix_last hold stable; pix_valid stays 1.
- A single bubble cycle (LOAD, pix_valid=0) occurs between rows.
- Frame with pix_ready tied 1: 121 pixel cycles + 11 LOAD cycles + 1 DONE = 133 cycles from busy rise to busy fall.
- done is asserted the cycle after the (10,10) handshake; pix_valid=0 in that cycle.
- A new start is accepted in the first IDLE cycle, 1 cycle after done.
- Reset during any state takes effect at the next edge: all outputs return to reset values and the partial frame is discarded with no done pulse.
- pix_ready is ignored outside STREAM.

## Test plan
- Reset, then start with digito=8 and pix_ready=1:
  - 121 pixels; pixels (3,1), (2,3), (8,7), (5,5) and (5,9) = 255; (0,0) and (5,3) = 0;
  - pix_last only at (10,10); done 1 cycle later; busy high for exactly 133 cycles.
- digito=1: FG only at x=8, y=2..4 and y=6..8 (6 pixels); every other pixel = 0; bad_digit=0.
- digito=12: all 121 pixels = 0; bad_digit=1 until the next start with digito=3, which clears it.
- Random pix_ready backpressure (~50%) with digito=0:
  - outputs stable during every stall;
  - pixel sequence identical to the pix_ready=1 run;
  - no pixel lost or duplicated.
- start pulsed with digito=7 at cycle 40 of a digito=2 frame: ignored; the frame completes as digit 2; a start after done renders 7.
- reset asserted while at pixel (4,6): next cycle busy=0, pix_valid=0, done never pulses; a following start renders a full frame from (0,0).
